// File: rtl/spu_result_forward_pipe.sv
// Result pipe for the dual-issue SPU datapath: carries each lane's execute result through
// DEPTH stages, answers decode-stage operand lookups with forward/stall, and drives writeback.
module spu_result_forward_pipe #(
  parameter int LANES   = 2,
  parameter int DEPTH   = 7,
  parameter int DATA_W  = 128,
  parameter int REG_AW  = 7,
  parameter int LAT_W   = 3,
  parameter int NUM_SRC = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [LANES-1:0]                  in_we,
  input  logic [LANES*REG_AW-1:0]           in_rt,
  input  logic [LANES*DATA_W-1:0]           in_data,
  input  logic [LANES*LAT_W-1:0]            in_lat,
  input  logic [LANES-1:0]                  flush,
  input  logic [LANES*NUM_SRC*REG_AW-1:0]   src_addr,
  input  logic [LANES*NUM_SRC-1:0]          src_used,
  output logic [LANES*NUM_SRC*DATA_W-1:0]   fwd_data,
  output logic [LANES*NUM_SRC-1:0]          fwd_hit,
  output logic [LANES-1:0]                  stall,
  output logic [LANES-1:0]                  wb_we,
  output logic [LANES*REG_AW-1:0]           wb_rt,
  output logic [LANES*DATA_W-1:0]           wb_data
);

  // Index 0 holds stage 1, index DEPTH-1 holds the writeback stage.
  logic [LANES-1:0]             stWe   [DEPTH];
  logic [LANES-1:0][REG_AW-1:0] stRt   [DEPTH];
  logic [LANES-1:0][DATA_W-1:0] stData [DEPTH];
  logic [LANES-1:0][LAT_W-1:0]  stLat  [DEPTH];

  logic [LANES*NUM_SRC-1:0][DATA_W-1:0] fwdDataArr;
  logic [LANES*NUM_SRC-1:0]             hitVec;
  logic [LANES-1:0]                     stallVec;
  logic [REG_AW-1:0]                    srcReg;
  logic                                 matchFound;
  logic                                 matchAvail;
  logic [DATA_W-1:0]                    matchData;
  logic [LAT_W-1:0]                     effLat;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        stWe[k]   <= '0;
        stRt[k]   <= '0;
        stData[k] <= '0;
        stLat[k]  <= '0;
      end
    end else begin
      stWe[0]   <= in_we & ~flush;
      stRt[0]   <= in_rt;
      stData[0] <= in_data;
      stLat[0]  <= in_lat;
      for (int k = 1; k < DEPTH; k++) begin
        stWe[k]   <= stWe[k-1];
        stRt[k]   <= stRt[k-1];
        stData[k] <= stData[k-1];
        stLat[k]  <= stLat[k-1];
      end
    end
  end

  // Scan oldest to youngest so the last match seen is the youngest; it alone decides
  // hit or stall, so an older ready copy can never bypass a younger pending one.
  always_comb begin
    hitVec     = '0;
    stallVec   = '0;
    fwdDataArr = '0;
    srcReg     = '0;
    matchFound = 1'b0;
    matchAvail = 1'b0;
    matchData  = '0;
    effLat     = '0;
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        srcReg     = src_addr[(l*NUM_SRC+s)*REG_AW +: REG_AW];
        matchFound = 1'b0;
        matchAvail = 1'b0;
        matchData  = '0;
        if (src_used[l*NUM_SRC+s] && (srcReg != '0)) begin
          for (int k = DEPTH-1; k >= 0; k--) begin
            for (int m = 0; m < LANES; m++) begin
              if (stWe[k][m] && (stRt[k][m] == srcReg)) begin
                effLat     = (stLat[k][m] == '0) ? LAT_W'(1) : stLat[k][m];
                matchFound = 1'b1;
                matchAvail = ((k + 1) >= int'(effLat));
                matchData  = stData[k][m];
              end
            end
          end
        end
        if (matchFound) begin
          if (matchAvail) begin
            hitVec[l*NUM_SRC+s]     = 1'b1;
            fwdDataArr[l*NUM_SRC+s] = matchData;
          end else begin
            stallVec[l] = 1'b1;
          end
        end
      end
    end
  end

  assign fwd_data = fwdDataArr;
  assign fwd_hit  = hitVec;
  assign stall    = stallVec;
  assign wb_we    = stWe[DEPTH-1];
  assign wb_rt    = stRt[DEPTH-1];
  assign wb_data  = stData[DEPTH-1];

endmodule

// File: tb/tb_spu_result_forward_pipe.sv
// Directed bench for spu_result_forward_pipe: a DEPTH=7 and a DEPTH=6 instance share
// one stimulus stream; the DEPTH=6 copy covers latencies beyond the pipe length.
module tb_spu_result_forward_pipe;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   in_we;
  logic [13:0]  in_rt;
  logic [255:0] in_data;
  logic [5:0]   in_lat;
  logic [1:0]   flush;
  logic [41:0]  src_addr;
  logic [5:0]   src_used;

  logic [767:0] fwd_data, fwd_data6;
  logic [5:0]   fwd_hit, fwd_hit6;
  logic [1:0]   stall, stall6;
  logic [1:0]   wb_we, wb_we6;
  logic [13:0]  wb_rt, wb_rt6;
  logic [255:0] wb_data, wb_data6;

  int checks = 0;
  int errors = 0;

  spu_result_forward_pipe #(.DEPTH(7)) dut (
    .clk(clk), .reset(reset), .in_we(in_we), .in_rt(in_rt), .in_data(in_data),
    .in_lat(in_lat), .flush(flush), .src_addr(src_addr), .src_used(src_used),
    .fwd_data(fwd_data), .fwd_hit(fwd_hit), .stall(stall), .wb_we(wb_we),
    .wb_rt(wb_rt), .wb_data(wb_data)
  );

  spu_result_forward_pipe #(.DEPTH(6)) dut6 (
    .clk(clk), .reset(reset), .in_we(in_we), .in_rt(in_rt), .in_data(in_data),
    .in_lat(in_lat), .flush(flush), .src_addr(src_addr), .src_used(src_used),
    .fwd_data(fwd_data6), .fwd_hit(fwd_hit6), .stall(stall6), .wb_we(wb_we6),
    .wb_rt(wb_rt6), .wb_data(wb_data6)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    in_we    = '0;
    flush    = '0;
    in_rt    = '0;
    in_data  = '0;
    in_lat   = '0;
    src_addr = '0;
    src_used = '0;
  endtask

  task automatic applyStimulus(input int lane, input logic [6:0] rt, input logic [127:0] data,
                               input logic [2:0] lat);
    in_we[lane]            = 1'b1;
    in_rt[lane*7 +: 7]     = rt;
    in_data[lane*128 +: 128] = data;
    in_lat[lane*3 +: 3]    = lat;
  endtask

  task automatic setSrc(input int lane, input int s, input logic [6:0] addr);
    src_addr[(lane*3+s)*7 +: 7] = addr;
    src_used[lane*3+s]          = 1'b1;
  endtask

  task automatic drain();
    clearIn();
    repeat (8) tick();
  endtask

  initial begin
    reset = 1'b1;
    clearIn();

    // Reset with live writes and a matching lookup: nothing may leak through.
    applyStimulus(0, 7'd5, 128'hA5, 3'd1);
    applyStimulus(1, 7'd5, 128'hB6, 3'd1);
    setSrc(1, 0, 7'd5);
    tick();
    tick();
    reset = 1'b0;
    in_we = '0;
    tick();
    checkOutput("rst_wb_we", 256'(wb_we), 256'(2'b00));
    checkOutput("rst_wb_rt", 256'(wb_rt), 256'd0);
    checkOutput("rst_wb_data", wb_data, 256'd0);
    checkOutput("rst_fwd_hit", 256'(fwd_hit), 256'd0);
    checkOutput("rst_stall", 256'(stall), 256'd0);
    checkOutput("rst_stall6", 256'(stall6), 256'd0);
    checkOutput("rst_wb_we6", 256'(wb_we6), 256'd0);
    drain();

    // Latency gate: lat=4 stalls at stages 1-3, forwards from stage 4.
    applyStimulus(0, 7'd5, 128'hAA, 3'd4);
    tick();
    clearIn();
    setSrc(1, 0, 7'd5);
    #1;
    for (int k = 1; k <= 3; k++) begin
      checkOutput($sformatf("lat_stall_s%0d", k), 256'(stall), 256'(2'b10));
      checkOutput($sformatf("lat_hit_s%0d", k), 256'(fwd_hit), 256'd0);
      tick();
    end
    checkOutput("lat_hit_s4", 256'(fwd_hit), 256'(6'b001000));
    checkOutput("lat_data_s4", 256'(fwd_data[3*128 +: 128]), 256'hAA);
    checkOutput("lat_stall_s4", 256'(stall), 256'd0);
    tick();
    tick();
    checkOutput("lat_wb_we6", 256'(wb_we6), 256'(2'b01));
    checkOutput("lat_wb_rt6", 256'(wb_rt6[6:0]), 256'd5);
    tick();
    checkOutput("lat_wb_we", 256'(wb_we), 256'(2'b01));
    checkOutput("lat_wb_rt", 256'(wb_rt[6:0]), 256'd5);
    checkOutput("lat_wb_data", 256'(wb_data[127:0]), 256'hAA);
    drain();

    // Youngest across stages.
    applyStimulus(0, 7'd9, 128'h11, 3'd1);
    tick();
    applyStimulus(0, 7'd9, 128'h22, 3'd1);
    tick();
    clearIn();
    setSrc(0, 1, 7'd9);
    #1;
    checkOutput("young_hit", 256'(fwd_hit), 256'(6'b000010));
    checkOutput("young_data", 256'(fwd_data[1*128 +: 128]), 256'h22);
    drain();

    // Youngest within one stage: lane 1 wins; both lanes reach writeback.
    applyStimulus(0, 7'd9, 128'h1, 3'd1);
    applyStimulus(1, 7'd9, 128'h2, 3'd1);
    tick();
    clearIn();
    setSrc(1, 2, 7'd9);
    #1;
    checkOutput("same_hit", 256'(fwd_hit), 256'(6'b100000));
    checkOutput("same_data", 256'(fwd_data[5*128 +: 128]), 256'h2);
    repeat (6) tick();
    checkOutput("same_wb_we", 256'(wb_we), 256'(2'b11));
    checkOutput("same_wb_data", wb_data, {128'h2, 128'h1});
    drain();

    // Younger unavailable entry shadows an older ready one.
    applyStimulus(0, 7'd3, 128'h33, 3'd1);
    tick();
    applyStimulus(0, 7'd3, 128'h44, 3'd6);
    tick();
    clearIn();
    setSrc(0, 0, 7'd3);
    #1;
    for (int k = 1; k <= 5; k++) begin
      checkOutput($sformatf("shadow_stall_s%0d", k), 256'(stall), 256'(2'b01));
      checkOutput($sformatf("shadow_hit_s%0d", k), 256'(fwd_hit), 256'd0);
      checkOutput($sformatf("shadow_data_s%0d", k), 256'(fwd_data[127:0]), 256'd0);
      tick();
    end
    checkOutput("shadow_hit_s6", 256'(fwd_hit), 256'(6'b000001));
    checkOutput("shadow_data_s6", 256'(fwd_data[127:0]), 256'h44);
    checkOutput("shadow_stall_s6", 256'(stall), 256'd0);
    drain();

    // Flushed lane-1 write: no match, no writeback.
    applyStimulus(1, 7'd8, 128'h88, 3'd1);
    flush = 2'b10;
    tick();
    clearIn();
    setSrc(0, 0, 7'd8);
    setSrc(1, 1, 7'd8);
    #1;
    checkOutput("flush_hit", 256'(fwd_hit), 256'd0);
    checkOutput("flush_stall", 256'(stall), 256'd0);
    repeat (6) tick();
    checkOutput("flush_wb_we", 256'(wb_we), 256'd0);
    drain();

    // Register 0 never forwards.
    applyStimulus(0, 7'd0, 128'h77, 3'd1);
    tick();
    clearIn();
    setSrc(0, 0, 7'd0);
    setSrc(1, 0, 7'd0);
    #1;
    checkOutput("r0_hit", 256'(fwd_hit), 256'd0);
    checkOutput("r0_stall", 256'(stall), 256'd0);
    drain();

    // lat=7: beyond DEPTH=6 it stalls until writeback; at DEPTH=7 it forwards at stage 7.
    applyStimulus(0, 7'd4, 128'h4C, 3'd7);
    tick();
    clearIn();
    setSrc(1, 0, 7'd4);
    #1;
    for (int k = 1; k <= 5; k++) begin
      checkOutput($sformatf("far_stall6_s%0d", k), 256'(stall6), 256'(2'b10));
      checkOutput($sformatf("far_hit6_s%0d", k), 256'(fwd_hit6), 256'd0);
      tick();
    end
    checkOutput("far_stall6_s6", 256'(stall6), 256'(2'b10));
    checkOutput("far_wb_we6", 256'(wb_we6), 256'(2'b01));
    checkOutput("far_stall_s6", 256'(stall), 256'(2'b10));
    tick();
    checkOutput("far_stall6_gone", 256'(stall6), 256'd0);
    checkOutput("far_hit6_gone", 256'(fwd_hit6), 256'd0);
    checkOutput("far_hit_s7", 256'(fwd_hit), 256'(6'b001000));
    checkOutput("far_data_s7", 256'(fwd_data[3*128 +: 128]), 256'h4C);
    checkOutput("far_stall_s7", 256'(stall), 256'd0);
    drain();

    // Mid-run reset while the entry sits at stage 3.
    applyStimulus(0, 7'd4, 128'h4C, 3'd7);
    tick();
    clearIn();
    setSrc(1, 0, 7'd4);
    tick();
    tick();
    checkOutput("mid_stall6_s3", 256'(stall6), 256'(2'b10));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("mid_stall6_rst", 256'(stall6), 256'd0);
    checkOutput("mid_stall_rst", 256'(stall), 256'd0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      checkOutput($sformatf("mid_wb_we_c%0d", k), 256'(wb_we), 256'd0);
      checkOutput($sformatf("mid_wb_we6_c%0d", k), 256'(wb_we6), 256'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spu_result_forward_pipe.md
Name: spu_result_forward_pipe

Overview:
- Parametrised result pipe and forwarding unit for the dual-issue SPU datapath.
- Replaces the fixed chain of 7 two-lane result-stage registers and the separate forwarding comparator.
- Carries each lane's execute result, destination register, write enable and unit latency through DEPTH stages.
- Answers operand-source lookups from the decode stage with forward data, a hit flag, or a stall.
- The last stage drives register-file writeback.

Parameters:
LANES, 2, issue lanes (lane 0 = even pipe, lane 1 = odd pipe; a higher lane index is younger within one issue group)
DEPTH, 7, result stages after execute (stage 1 .. DEPTH); DEPTH >= 2
DATA_W, 128, result width
REG_AW, 7, register address width
LAT_W, 3, latency field width
NUM_SRC, 3, source operands looked up per lane (RA, RB, RC)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_we  in  LANES  per-lane write enable of the instruction leaving execute
in_rt  in  LANES*REG_AW  per-lane destination register
in_data  in  LANES*DATA_W  per-lane result
in_lat  in  LANES*LAT_W  per-lane unit latency (stage at which the result becomes forwardable)
flush  in  LANES  per-lane kill of the entering instruction
src_addr  in  LANES*NUM_SRC*REG_AW  decode-stage source register addresses
src_used  in  LANES*NUM_SRC  source actually read by the instruction
fwd_data  out  LANES*NUM_SRC*DATA_W  forwarded operand
fwd_hit  out  LANES*NUM_SRC  use fwd_data instead of the register file
stall  out  LANES  lane must hold in decode
wb_we  out  LANES  writeback enable (stage DEPTH)
wb_rt  out  LANES*REG_AW  writeback register
wb_data  out  LANES*DATA_W  writeback data

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: every stage entry gets we=0, rt=0, data=0, lat=0. Therefore wb_we=0, wb_rt=0, wb_data=0, fwd_hit=0, fwd_data=0 and stall=0 in the cycle after reset. Reset mid-operation discards all in-flight results, with no writeback.
- Shift: each edge, stage k moves to stage k+1 for all lanes. Stage 1 captures in_* per lane; in_we is forced to 0 where flush[l]=1. The pipe never holds; the caller supplies bubbles (in_we=0) while stalled.
- Latency: an entry at stage k is available when k >= max(in_lat,1).
  - lat > DEPTH means never available in the pipe.
  - A consumer matching such an entry stalls until it has written back. After that there is no match, and the register file supplies the value.
- Match: an entry matches source (l,s) when its we=1, its rt == src_addr, src_used=1, and src_addr != 0. Register 0 is never forwarded.
- Priority: the youngest matching entry wins. Order is smallest stage k first; within one stage, the higher lane index wins.
- Result, all combinational from current stage state:
  - Winner available: fwd_hit=1 and fwd_data=winner data.
  - Winner not available: fwd_hit=0, fwd_data=0, and stall[l]=1.
  - No match: fwd_hit=0, fwd_data=0.
  - An older, available match never overrides a younger, unavailable one.
- stall[l] is the OR over that lane's sources.
- Writeback: wb_* equal stage DEPTH contents for each lane.
  - If both lanes write the same rt in one cycle, both are presented; the register file resolves the conflict with lane 1 winning.
  - A result is visible at wb_* exactly DEPTH cycles after capture.
- Out of scope: no comparison against the in_* entering this cycle. Same-group lane0→lane1 dependencies are resolved by the issue logic.

Test Plan:
- Reset to empty: assert reset 2 cycles with in_we=11 → wb_we=00, fwd_hit=0, stall=00 on the cycle after release.
- Latency gate: lane0 in_we=1, rt=5, data=0xAA, lat=4; lane1 src RA=5 → stall[1]=1 while the entry is at stages 1–3. At stage 4: fwd_hit=1, fwd_data=0xAA, stall=0. After 7 cycles: wb_we[0]=1, wb_rt=5, wb_data=0xAA.
- Youngest wins: lane0 rt=9 data=0x11 lat=1 captured, then the next cycle lane0 rt=9 data=0x22 lat=1 → lookup of 9 returns 0x22. Same-stage test: lane0 rt=9 data=1 and lane1 rt=9 data=2 → returns 2.
- Younger unavailable shadows older: rt=3 data=0x33 lat=1 captured, then rt=3 lat=6 → stall=1 for src 3 until the younger entry reaches stage 6; it is never 0x33.
- Flush and r0: flush[1]=1 with in_we[1]=1, rt=8 → no match on 8, and wb_we[1]=0 seven cycles later. A lookup of src 0 against an entry with rt=0, we=1 gives fwd_hit=0.
- lat > DEPTH with mid-run reset: rt=4 lat=7 with DEPTH=6 → src 4 stalls for 6 cycles, then fwd_hit=0, stall=0. Asserting reset at stage 3 in a repeat run → stall drops the next cycle and no writeback occurs.
